// File: rtl/regfile_pkg.sv
// Shared widths and types for the RV64 integer register file, decode and ALU.
package regfile_pkg;

   localparam int XLEN  = 64;
   localparam int NREGS = 32;

   typedef logic [4:0]      reg_idx_t;
   typedef logic [XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits plus RAW/WAW issue gating; iss_ready is combinational, state updates next edge.
// REGFILE_BYPASS_EN lets a same-cycle writeback resolve a busy source.
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     iss_valid,
   input  reg_idx_t iss_rs1,
   input  reg_idx_t iss_rs2,
   input  reg_idx_t iss_rd,
   input  logic     iss_rd_we,
   input  logic     wb_en,
   input  reg_idx_t wb_dest,
   output logic     iss_ready
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic             rs1_resolved, rs2_resolved;
   logic             rs1_blocked, rs2_blocked, waw_blocked;
   logic             iss_fire;

`ifdef REGFILE_BYPASS_EN
   assign rs1_resolved = wb_en && (wb_dest == iss_rs1) && (iss_rs1 != '0);
   assign rs2_resolved = wb_en && (wb_dest == iss_rs2) && (iss_rs2 != '0);
`else
   assign rs1_resolved = 1'b0;
   assign rs2_resolved = 1'b0;
`endif

   assign rs1_blocked = busy_q[iss_rs1] && !rs1_resolved;
   assign rs2_blocked = busy_q[iss_rs2] && !rs2_resolved;
   assign waw_blocked = iss_rd_we && busy_q[iss_rd];
   assign iss_ready   = !rs1_blocked && !rs2_blocked && !waw_blocked;
   assign iss_fire    = iss_valid && iss_ready;

   // Set after clear: a newly issued producer outranks the retiring one.
   always_comb begin
      busy_d = busy_q;
      if (wb_en) begin
         busy_d[wb_dest] = 1'b0;
      end
      if (iss_fire && iss_rd_we && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/regfile_wb.sv
// Register file + operand-issue stage: operands appear 1 cycle after an accepted issue, writes land next edge.
// Issue is held off by the scoreboard; REGFILE_BYPASS_EN forwards same-cycle writeback data to the operands.
module regfile_wb
   import regfile_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        iss_valid,
   output logic        iss_ready,
   input  reg_idx_t    iss_rs1,
   input  reg_idx_t    iss_rs2,
   input  reg_idx_t    iss_rd,
   input  logic        iss_rd_we,
   output logic        op_valid,
   output xlen_t       regA_value,
   output xlen_t       regB_value,
   output reg_idx_t    regDest,
   input  logic        wb_en,
   input  reg_idx_t    wb_dest,
   input  xlen_t       wb_data,
   output logic [31:0] stall_count
);

   xlen_t       mem_q [NREGS];
   xlen_t       rd_a, rd_b;
   logic        op_valid_q, op_valid_d;
   xlen_t       rega_q, rega_d, regb_q, regb_d;
   reg_idx_t    dest_q, dest_d;
   logic [31:0] stall_q, stall_d;
   logic        iss_fire;

   regfile_scoreboard u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_rs1   (iss_rs1),
      .iss_rs2   (iss_rs2),
      .iss_rd    (iss_rd),
      .iss_rd_we (iss_rd_we),
      .wb_en     (wb_en),
      .wb_dest   (wb_dest),
      .iss_ready (iss_ready)
   );

   assign iss_fire = iss_valid && iss_ready;

   always_comb begin
      rd_a = (iss_rs1 == '0) ? '0 : mem_q[iss_rs1];
      rd_b = (iss_rs2 == '0) ? '0 : mem_q[iss_rs2];
`ifdef REGFILE_BYPASS_EN
      if (wb_en && (wb_dest == iss_rs1) && (iss_rs1 != '0)) begin
         rd_a = wb_data;
      end
      if (wb_en && (wb_dest == iss_rs2) && (iss_rs2 != '0)) begin
         rd_b = wb_data;
      end
`endif
   end

   always_comb begin
      op_valid_d = iss_fire;
      rega_d     = rega_q;
      regb_d     = regb_q;
      dest_d     = dest_q;
      stall_d    = stall_q;
      if (iss_fire) begin
         rega_d = rd_a;
         regb_d = rd_b;
         dest_d = iss_rd;
      end
      if (iss_valid && !iss_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // x0 is never written, so its reset value of zero is permanent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wb_en && (wb_dest != '0)) begin
         mem_q[wb_dest] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_valid_q <= 1'b0;
         rega_q     <= '0;
         regb_q     <= '0;
         dest_q     <= '0;
         stall_q    <= '0;
      end else begin
         op_valid_q <= op_valid_d;
         rega_q     <= rega_d;
         regb_q     <= regb_d;
         dest_q     <= dest_d;
         stall_q    <= stall_d;
      end
   end

   assign op_valid    = op_valid_q;
   assign regA_value  = rega_q;
   assign regB_value  = regb_q;
   assign regDest     = dest_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb; expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_wb;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        iss_valid;
   logic        iss_ready;
   reg_idx_t    iss_rs1, iss_rs2, iss_rd;
   logic        iss_rd_we;
   logic        op_valid;
   xlen_t       regA_value, regB_value;
   reg_idx_t    regDest;
   logic        wb_en;
   reg_idx_t    wb_dest;
   xlen_t       wb_data;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

   regfile_wb dut (
      .clk         (clk),
      .reset       (reset),
      .iss_valid   (iss_valid),
      .iss_ready   (iss_ready),
      .iss_rs1     (iss_rs1),
      .iss_rs2     (iss_rs2),
      .iss_rd      (iss_rd),
      .iss_rd_we   (iss_rd_we),
      .op_valid    (op_valid),
      .regA_value  (regA_value),
      .regB_value  (regB_value),
      .regDest     (regDest),
      .wb_en       (wb_en),
      .wb_dest     (wb_dest),
      .wb_data     (wb_data),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input int rs1, input int rs2, input int rd, input logic we);
      iss_valid = v;
      iss_rs1   = reg_idx_t'(rs1);
      iss_rs2   = reg_idx_t'(rs2);
      iss_rd    = reg_idx_t'(rd);
      iss_rd_we = we;
   endtask

   task automatic wb(input logic en, input int dest, input logic [63:0] data);
      wb_en   = en;
      wb_dest = reg_idx_t'(dest);
      wb_data = data;
   endtask

   initial begin
      reset = 1'b0;
      issue(1'b0, 0, 0, 0, 1'b0);
      wb(1'b0, 0, 64'h0);
      #1;
      check("rst_op_valid", op_valid, 0);
      check("rst_regA", regA_value, 0);
      check("rst_regB", regB_value, 0);
      check("rst_regDest", regDest, 0);
      check("rst_stall", stall_count, 0);
      check("rst_ready", iss_ready, 1);
      step();
      step();
      reset = 1'b1;

      // Issue of x0/x0
      issue(1'b1, 0, 0, 1, 1'b0);
      #1 check("x0_ready", iss_ready, 1);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("x0_op_valid", op_valid, 1);
      check("x0_regA", regA_value, 0);
      check("x0_regB", regB_value, 0);
      check("x0_regDest", regDest, 1);
      step();
      check("idle_op_valid", op_valid, 0);
      check("idle_regDest_hold", regDest, 1);
      check("idle_stall", stall_count, 0);

      // Writeback then read
      wb(1'b1, 5, 64'h1234);
      step();
      wb(1'b0, 0, 64'h0);
      issue(1'b1, 5, 0, 2, 1'b0);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("wb_read_regA", regA_value, 64'h1234);
      check("wb_read_op_valid", op_valid, 1);

      // RAW on x7
      issue(1'b1, 0, 0, 7, 1'b1);
      #1 check("raw_prod_ready", iss_ready, 1);
      step();
      issue(1'b1, 7, 0, 8, 1'b0);
      #1 check("raw_stall_ready", iss_ready, 0);
      step();
      wb(1'b1, 7, 64'hABCD);
`ifdef REGFILE_BYPASS_EN
      #1 check("raw_wb_ready", iss_ready, 1);
      step();
      wb(1'b0, 0, 64'h0);
      issue(1'b0, 0, 0, 0, 1'b0);
      check("raw_op_valid", op_valid, 1);
      check("raw_regA", regA_value, 64'hABCD);
      check("raw_regDest", regDest, 8);
      check("raw_stall", stall_count, 1);
`else
      #1 check("raw_wb_ready", iss_ready, 0);
      step();
      wb(1'b0, 0, 64'h0);
      #1 check("raw_after_ready", iss_ready, 1);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("raw_op_valid", op_valid, 1);
      check("raw_regA", regA_value, 64'hABCD);
      check("raw_regDest", regDest, 8);
      check("raw_stall", stall_count, 2);
`endif

      // x0 writes discarded, rd=0 never blocks
      wb(1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      wb(1'b0, 0, 64'h0);
      issue(1'b1, 0, 0, 0, 1'b1);
      #1 check("x0w_ready", iss_ready, 1);
      step();
      check("x0w_regB", regB_value, 0);
      issue(1'b1, 5, 0, 3, 1'b0);
      #1 check("x0_reader_ready", iss_ready, 1);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("x0_reader_op_valid", op_valid, 1);
      check("x0_reader_regB", regB_value, 0);
      check("x0_reader_regA", regA_value, 64'h1234);

      // Same-cycle set and clear of x9: set wins
      issue(1'b1, 0, 0, 9, 1'b1);
      wb(1'b1, 9, 64'h99);
      #1 check("same_ready", iss_ready, 1);
      step();
      wb(1'b0, 0, 64'h0);
      issue(1'b1, 9, 0, 10, 1'b0);
      #1 check("same_busy_ready0", iss_ready, 0);
      step();
      #1 check("same_busy_ready1", iss_ready, 0);
      step();
      wb(1'b1, 9, 64'h55);
`ifdef REGFILE_BYPASS_EN
      #1 check("same_wb_ready", iss_ready, 1);
      step();
      wb(1'b0, 0, 64'h0);
      issue(1'b0, 0, 0, 0, 1'b0);
      check("same_regA", regA_value, 64'h55);
      check("same_stall", stall_count, 3);
`else
      #1 check("same_wb_ready", iss_ready, 0);
      step();
      wb(1'b0, 0, 64'h0);
      #1 check("same_after_ready", iss_ready, 1);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("same_regA", regA_value, 64'h55);
      check("same_stall", stall_count, 5);
`endif

      // Reset asserted mid-stall
      issue(1'b1, 5, 0, 11, 1'b1);
      step();
      check("pre_rst_regA", regA_value, 64'h1234);
      check("pre_rst_regDest", regDest, 11);
      issue(1'b1, 11, 0, 12, 1'b0);
      #1 check("pre_rst_ready", iss_ready, 0);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_op_valid", op_valid, 0);
      check("mid_rst_regA", regA_value, 0);
      check("mid_rst_regDest", regDest, 0);
      check("mid_rst_stall", stall_count, 0);
      check("mid_rst_ready", iss_ready, 1);
      issue(1'b0, 0, 0, 0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      issue(1'b1, 11, 0, 12, 1'b0);
      #1 check("post_rst_ready", iss_ready, 1);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("post_rst_op_valid", op_valid, 1);
      check("post_rst_regA", regA_value, 0);
      check("post_rst_regDest", regDest, 12);
      wb(1'b1, 11, 64'h77);
      step();
      wb(1'b0, 0, 64'h0);
      issue(1'b1, 11, 5, 13, 1'b0);
      step();
      issue(1'b0, 0, 0, 0, 1'b0);
      check("post_rst_wb_regA", regA_value, 64'h77);
      check("post_rst_wb_regB", regB_value, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
